// File: rtl/fu_wb_arbiter.sv
// Write-back collector: one holding slot per functional unit. The slots drain
// round-robin onto the single register-file write port, one per cycle.
module fu_wb_arbiter #(
  parameter int N_SRC = 5,
  parameter int DW    = 32,
  parameter int AW    = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_SRC-1:0]      fu_finish,
  input  logic [N_SRC*DW-1:0]   fu_res,
  input  logic [N_SRC*AW-1:0]   fu_rd,
  output logic [N_SRC-1:0]      fu_busy,
  output logic                  wb_en,
  output logic [AW-1:0]         wb_addr,
  output logic [DW-1:0]         wb_data,
  output logic [N_SRC-1:0]      wb_src,
  output logic                  ovf
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [N_SRC-1:0] r_valid;
  logic [DW-1:0]    r_data [N_SRC];
  logic [AW-1:0]    r_rd   [N_SRC];
  logic [PW-1:0]    r_ptr;
  logic             r_wb_en;
  logic [AW-1:0]    r_wb_addr;
  logic [DW-1:0]    r_wb_data;
  logic [N_SRC-1:0] r_wb_src;
  logic             r_ovf;

  logic             w_gnt_any;
  logic [PW-1:0]    w_gnt_idx;
  logic [N_SRC-1:0] w_gnt_oh;
  logic [DW-1:0]    w_sel_data;
  logic [AW-1:0]    w_sel_rd;
  logic [PW-1:0]    w_ptr_nxt;
  logic [PW-1:0]    w_idx;

  function automatic logic [PW-1:0] wrap_idx(input int unsigned v);
    int unsigned r;
    r = (v >= N_SRC) ? v - N_SRC : v;
    return PW'(r);
  endfunction

  // Scan upward from r_ptr, modulo N_SRC; first valid slot wins.
  always_comb begin
    w_gnt_any  = 1'b0;
    w_gnt_idx  = '0;
    w_gnt_oh   = '0;
    w_sel_data = '0;
    w_sel_rd   = '0;
    w_idx      = '0;
    for (int unsigned k = 0; k < N_SRC; k++) begin
      w_idx = wrap_idx(32'(r_ptr) + k);
      if (!w_gnt_any && r_valid[w_idx]) begin
        w_gnt_any  = 1'b1;
        w_gnt_idx  = w_idx;
        w_sel_data = r_data[w_idx];
        w_sel_rd   = r_rd[w_idx];
      end
    end
    if (w_gnt_any) w_gnt_oh[w_gnt_idx] = 1'b1;
    w_ptr_nxt = (w_gnt_idx == PW'(N_SRC - 1)) ? '0 : w_gnt_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_ptr     <= '0;
      r_wb_en   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
      r_wb_src  <= '0;
      r_ovf     <= 1'b0;
      for (int unsigned i = 0; i < N_SRC; i++) begin
        r_data[i] <= '0;
        r_rd[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_SRC; i++) begin
        if (fu_finish[i]) begin
          // A slot being granted this edge is free to reload in the same edge.
          if (!r_valid[i] || w_gnt_oh[i]) begin
            r_valid[i] <= 1'b1;
            r_data[i]  <= fu_res[i*DW +: DW];
            r_rd[i]    <= fu_rd[i*AW +: AW];
          end else begin
            r_ovf <= 1'b1;
          end
        end else if (w_gnt_oh[i]) begin
          r_valid[i] <= 1'b0;
        end
      end

      r_wb_src <= w_gnt_oh;
      if (w_gnt_any) begin
        r_wb_en   <= (w_sel_rd != '0);
        r_wb_addr <= w_sel_rd;
        r_wb_data <= w_sel_data;
        r_ptr     <= w_ptr_nxt;
      end else begin
        r_wb_en   <= 1'b0;
      end
    end
  end

  assign fu_busy = r_valid;
  assign wb_en   = r_wb_en;
  assign wb_addr = r_wb_addr;
  assign wb_data = r_wb_data;
  assign wb_src  = r_wb_src;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_fu_wb_arbiter.sv
// Scoreboard bench for fu_wb_arbiter: stimulus pushes expected write-backs,
// a monitor pops and compares whenever wb_src is non-zero.
module tb_fu_wb_arbiter;
  localparam int N  = 5;
  localparam int DW = 32;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    fu_finish = '0;
  logic [N*DW-1:0] fu_res = '0;
  logic [N*AW-1:0] fu_rd = '0;
  logic [N-1:0]    fu_busy;
  logic            wb_en;
  logic [AW-1:0]   wb_addr;
  logic [DW-1:0]   wb_data;
  logic [N-1:0]    wb_src;
  logic            ovf;

  fu_wb_arbiter #(.N_SRC(N), .DW(DW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .fu_finish(fu_finish), .fu_res(fu_res),
    .fu_rd(fu_rd), .fu_busy(fu_busy), .wb_en(wb_en), .wb_addr(wb_addr),
    .wb_data(wb_data), .wb_src(wb_src), .ovf(ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  src;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          en;
  } wb_t;

  wb_t q[$];
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic load(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    fu_res[i*DW +: DW] = d;
    fu_rd[i*AW +: AW]  = rd;
    fu_finish[i]       = 1'b1;
  endtask

  task automatic expect_wb(input int i, input logic [AW-1:0] rd, input logic [DW-1:0] d);
    wb_t e;
    e.src  = N'(1) << i;
    e.addr = rd;
    e.data = d;
    e.en   = (rd != 0);
    q.push_back(e);
  endtask

  task automatic idle_inputs();
    fu_finish = '0;
    fu_res    = {N{32'hBAD0_BAD0}};
    fu_rd     = {N{5'd31}};
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every write-back must match the head of the scoreboard.
  initial begin
    wb_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wb_src != '0) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_wb actual_src=%0h actual_addr=%0h actual_data=%0h required=none",
                     wb_src, wb_addr, wb_data);
          end else begin
            e = q.pop_front();
            check("wb_src",  64'(wb_src),  64'(e.src));
            check("wb_addr", 64'(wb_addr), 64'(e.addr));
            check("wb_data", 64'(wb_data), 64'(e.data));
            check("wb_en",   64'(wb_en),   64'(e.en));
          end
        end else begin
          check("idle_wb_en", 64'(wb_en), 64'd0);
        end
      end
    end
  end

  initial begin
    int budget;
    idle_inputs();
    #1;
    check("rst_wb_en",   64'(wb_en),   64'd0);
    check("rst_wb_src",  64'(wb_src),  64'd0);
    check("rst_wb_addr", 64'(wb_addr), 64'd0);
    check("rst_wb_data", 64'(wb_data), 64'd0);
    check("rst_busy",    64'(fu_busy), 64'd0);
    check("rst_ovf",     64'(ovf),     64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Single MUL result with latency and busy-width checks
    @(negedge clk);
    load(1, 5'd7, 32'h0000_0C35);
    expect_wb(1, 5'd7, 32'h0000_0C35);
    @(negedge clk);
    idle_inputs();
    check("mul_busy_after_e0", 64'(fu_busy), 64'h02);
    check("mul_no_wb_yet",     64'(wb_src),  64'h00);
    @(negedge clk);
    check("mul_wb_en_after_e1", 64'(wb_en),   64'd1);
    check("mul_busy_cleared",   64'(fu_busy), 64'h00);
    @(negedge clk);
    check("mul_wb_src_drop", 64'(wb_src), 64'h00);

    // Simultaneous finish from ptr=0
    do_reset();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      load(i, AW'(i + 1), 32'(17 * (i + 1)));
      expect_wb(i, AW'(i + 1), 32'(17 * (i + 1)));
    end
    @(negedge clk);
    idle_inputs();
    check("all_busy", 64'(fu_busy), 64'h1F);
    repeat (6) @(negedge clk);
    check("rr_ovf", 64'(ovf), 64'd0);
    check("rr_busy_empty", 64'(fu_busy), 64'h00);

    // Pointer rotation: ALU granted alone, then ALU+JUMP -> JUMP first
    @(negedge clk);
    load(0, 5'd11, 32'h100);
    expect_wb(0, 5'd11, 32'h100);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    load(0, 5'd12, 32'h200);
    load(4, 5'd13, 32'h300);
    expect_wb(4, 5'd13, 32'h300);
    expect_wb(0, 5'd12, 32'h200);
    @(negedge clk);
    idle_inputs();
    repeat (4) @(negedge clk);

    // rd=0 release from DIV
    load(2, 5'd0, 32'hDEAD_BEEF);
    expect_wb(2, 5'd0, 32'hDEAD_BEEF);
    @(negedge clk);
    idle_inputs();
    repeat (3) @(negedge clk);

    // MEM capture-while-grant
    load(3, 5'd9, 32'hA);
    expect_wb(3, 5'd9, 32'hA);
    @(negedge clk);
    idle_inputs();
    load(3, 5'd10, 32'hB);
    expect_wb(3, 5'd10, 32'hB);
    @(negedge clk);
    idle_inputs();
    check("cwg_busy_kept", 64'(fu_busy), 64'h08);
    repeat (3) @(negedge clk);
    check("cwg_ovf", 64'(ovf), 64'd0);

    // Overflow: ptr moved to MUL, ALU waits and is pulsed again
    load(0, 5'd14, 32'h400);
    expect_wb(0, 5'd14, 32'h400);
    @(negedge clk);
    idle_inputs();
    repeat (2) @(negedge clk);
    load(0, 5'd15, 32'h500);
    load(1, 5'd16, 32'h600);
    expect_wb(1, 5'd16, 32'h600);
    expect_wb(0, 5'd15, 32'h500);
    @(negedge clk);
    idle_inputs();
    load(0, 5'd17, 32'h700);
    @(negedge clk);
    idle_inputs();
    check("ovf_set", 64'(ovf), 64'd1);
    repeat (4) @(negedge clk);
    check("ovf_sticky", 64'(ovf), 64'd1);

    // Async reset with three slots still valid
    load(0, 5'd21, 32'h1111);
    load(1, 5'd22, 32'h2222);
    load(2, 5'd23, 32'h3333);
    load(3, 5'd24, 32'h4444);
    expect_wb(1, 5'd22, 32'h2222);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);
    #2;
    check("pre_reset_busy", 64'(fu_busy), 64'h0D);
    rst_n = 1'b0;
    #1;
    check("arst_wb_en",   64'(wb_en),   64'd0);
    check("arst_wb_src",  64'(wb_src),  64'd0);
    check("arst_wb_addr", 64'(wb_addr), 64'd0);
    check("arst_wb_data", 64'(wb_data), 64'd0);
    check("arst_busy",    64'(fu_busy), 64'd0);
    check("arst_ovf",     64'(ovf),     64'd0);
    fu_finish = '1;
    repeat (2) @(negedge clk);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("post_reset_busy", 64'(fu_busy), 64'd0);

    load(0, 5'd20, 32'h900);
    expect_wb(0, 5'd20, 32'h900);
    @(negedge clk);
    idle_inputs();

    budget = 50;
    while (q.size() != 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 64'(q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fu_wb_arbiter.md
# fu_wb_arbiter

Write-back collector for the execution functional units (ALU, MUL, DIV, MEM, JUMP). It captures each unit's one-cycle `finish` pulse with its 32-bit result and destination tag into a per-unit holding slot. It then drains the slots round-robin onto the single register-file write port, one per cycle. It sits directly downstream of the FU outputs and upstream of the register file and scoreboard release logic.

## Interface
- `N_SRC`, 5: number of functional-unit sources; index 0 = ALU, 1 = MUL, 2 = DIV, 3 = MEM, 4 = JUMP.
- `DW`, 32: result width.
- `AW`, 5: destination register index width.

Ports:
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `fu_finish`  in  N_SRC  per-source one-cycle completion pulse.
- `fu_res`  in  N_SRC*DW  per-source result; slice i = bits [i*DW +: DW]; valid only in the `fu_finish[i]` cycle.
- `fu_rd`  in  N_SRC*AW  per-source destination index, sliced like `fu_res`.
- `fu_busy`  out  N_SRC  slot i occupied; issue logic must not start unit i while high.
- `wb_en`  out  1  register-file write enable.
- `wb_addr`  out  AW  write index.
- `wb_data`  out  DW  write data.
- `wb_src`  out  N_SRC  one-hot source of the current write-back (scoreboard release); all-zero when idle.
- `ovf`  out  1  sticky overflow flag.

## Operation
- Each source has one holding slot: `valid`, `data[DW]`, `rd[AW]`.
- Capture: at an edge where `fu_finish[i]`=1, slot i loads `fu_res`/`fu_rd` slice i and sets `valid`.
- Arbitration:
  - Combinational over the valid slots, round-robin.
  - Search starts at `ptr`, scans upward modulo N_SRC, and grants the first valid slot.
  - At most one grant per cycle.
- On grant g at an edge:
  - Slot g clears `valid`.
  - `wb_src` ← one-hot(g); `wb_addr` ← rd_g; `wb_data` ← data_g.
  - `wb_en` ← (rd_g != 0).
  - `ptr` ← (g+1) mod N_SRC.
- No grant: `wb_en`=0 and `wb_src`=0; `wb_addr`/`wb_data` hold their previous values; `ptr` unchanged.
- rd = 0: `wb_en` stays 0 but `wb_src` still pulses, so the scoreboard entry is released.
- Capture and grant of the same slot at one edge: the slot is emitted from its old contents and reloaded with the new ones; `valid` stays 1; no overflow.
- Capture into a valid slot that is not granted that edge:
  - The new data is dropped and the old contents are kept.
  - `ovf` ← 1 and stays 1 until reset.
- `fu_busy[i]` = slot i `valid`, driven directly from the flop.
- Results are not reordered within a source. Across sources the order is arbitration order, not completion order. The scoreboard guarantees no WAW hazards between in-flight sources.

## Timing
- Reset (async assert, sync-safe deassert) values:
  - All slot `valid` = 0.
  - `ptr` = 0.
  - `wb_en` = 0, `wb_src` = 0, `wb_addr` = 0, `wb_data` = 0.
  - `ovf` = 0, `fu_busy` = 0.
- Reset mid-operation discards all held results with no write-back; in-flight FU pulses during reset are ignored.
- Latency, uncontended:
  - `fu_finish` sampled at edge E0; slot valid after E0.
  - Granted at E1; `wb_en`/`wb_addr`/`wb_data`/`wb_src` visible for the cycle after E1.
  - Total: 2 edges from the finish pulse.
- `fu_busy[i]` rises after E0 and falls after the granting edge.
- Throughput: one write-back per cycle. A source held continuously waits at most N_SRC−1 grants (starvation bound).
- All outputs are registered; there is no combinational path from `fu_*` inputs to `wb_*`.

## Test plan
- **Single MUL result:** `fu_finish`=5'b00010, MUL res=0x0000_0C35, rd=7 at E0.
  - One cycle after E1: `wb_en`=1, `wb_addr`=7, `wb_data`=0x0000_0C35, `wb_src`=5'b00010.
  - Next cycle: `wb_en`=0, `wb_src`=0.
  - `fu_busy[1]` high for exactly one cycle.
- **Simultaneous finish, round-robin:** all 5 pulse at E0 with rd=1..5 and res=0x11..0x55, `ptr`=0.
  - Write-backs on consecutive cycles in order rd 1, 2, 3, 4, 5.
  - `ptr` ends at 0; `ovf`=0.
- **Pointer rotation:** after ALU is granted (`ptr`=1), ALU and JUMP both pulse.
  - JUMP is written first, then ALU.
- **rd=0 release:** DIV finishes with rd=0, res=0xDEAD_BEEF.
  - `wb_en` stays 0; `wb_src`=5'b00100 for one cycle.
- **Capture-while-grant and overflow:**
  - MEM pulses (rd=9, 0xA), then pulses again (rd=10, 0xB) at the edge where slot 3 is granted.
    - Both are written in order; `ovf`=0.
  - Then hold ALU and MUL valid with `ptr` at MUL so ALU waits, and pulse ALU again.
    - `ovf`=1; the original ALU data is written and the new data is dropped.
- **Async reset:** assert `rst_n`=0 mid-cycle with 3 slots valid.
  - Outputs go to their reset values immediately.
  - After release, no write-back occurs until a new `fu_finish`.
